// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, control codes, write-back FSM states.
// Pure types, constants and a load-formatting helper; no timing or flow control.
package core_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH  = 5;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int GPR_CTRL_WIDTH = 3;
  localparam int CSR_CTRL_WIDTH = 2;
  localparam int MEM_CTRL_WIDTH = 4;

  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_IDLE = 3'd0;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_ALU  = 3'd1;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_MEM  = 3'd2;
  localparam logic [GPR_CTRL_WIDTH-1:0] GPR_OP3  = 3'd3;

  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_IDLE = 2'd0;
  localparam logic [CSR_CTRL_WIDTH-1:0] CSR_ALU  = 2'd1;

  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_IDLE = 4'd0;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB   = 4'd1;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU  = 4'd2;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH   = 4'd3;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU  = 4'd4;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW   = 4'd5;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB   = 4'd6;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH   = 4'd7;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW   = 4'd8;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_RSP = 2'd1,
    WB_COMMIT   = 2'd2
  } wb_state_e;

  localparam int WB_RSP_TIMEOUT_DEFAULT = 255;

  // Extract the addressed byte/half from a word-aligned response and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_format(
    input logic [MEM_CTRL_WIDTH-1:0] mem_ctrl,
    input logic [1:0]                offset,
    input logic [DATA_WIDTH-1:0]     rdata
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    sh = rdata >> {offset, 3'b000};
    case (mem_ctrl)
      MEM_RB:  res = {{24{sh[7]}}, sh[7:0]};
      MEM_RBU: res = {24'b0, sh[7:0]};
      MEM_RH:  res = {{16{sh[15]}}, sh[15:0]};
      MEM_RHU: res = {16'b0, sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_unit.sv
// Combinational formatting of GPR/CSR write data from the held instruction.
// Zero latency, no flow control; outputs are meaningful only under the strobes.
module writeback_unit
  import core_pkg::*;
(
  input  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_i,
  input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
  input  logic [DATA_WIDTH-1:0]     exe_out_i,
  input  logic [DATA_WIDTH-1:0]     op3_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic [RF_ADDR_WIDTH-1:0]  rd_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  output logic [RF_ADDR_WIDTH-1:0]  rd_o,
  output logic [DATA_WIDTH-1:0]     gpr_wdata_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o
);

  always_comb begin
    rd_o        = rd_i;
    csr_waddr_o = csr_waddr_i;
    csr_wdata_o = exe_out_i;
    case (gpr_ctrl_i)
      GPR_MEM: gpr_wdata_o = load_format(mem_ctrl_i, exe_out_i[1:0], rdata_i);
      GPR_OP3: gpr_wdata_o = op3_i;
      default: gpr_wdata_o = exe_out_i;
    endcase
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Write-back sequencer: holds one retiring instruction, waits on OBI R for loads, strobes GPR/CSR.
// Non-load commits 1 cycle after accept; loads commit 1 cycle after rvalid; ready_o low while waiting.
module writeback_ctrl
  import core_pkg::*;
#(
  parameter int RSP_TIMEOUT   = WB_RSP_TIMEOUT_DEFAULT,
  parameter int INSTRET_WIDTH = 64
)
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_WIDTH-1:0]     exe_out_i,
  input  logic [DATA_WIDTH-1:0]     op3_i,
  input  logic [RF_ADDR_WIDTH-1:0]  rd_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_i,
  input  logic [CSR_CTRL_WIDTH-1:0] csr_ctrl_i,
  input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      err_i,
  output logic [RF_ADDR_WIDTH-1:0]  rd_o,
  output logic [DATA_WIDTH-1:0]     gpr_wdata_o,
  output logic                      gpr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      csr_we_o,
  output logic                      retire_o,
  output logic                      load_err_o,
  output logic                      timeout_o,
  output logic [INSTRET_WIDTH-1:0]  instret_o
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RSP_TIMEOUT);

  wb_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [INSTRET_WIDTH-1:0]  instret_q, instret_d;
  logic                      accept;

  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_q;
  logic [CSR_CTRL_WIDTH-1:0] csr_ctrl_q;
  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_q;
  logic [DATA_WIDTH-1:0]     exe_out_q, op3_q, rdata_q;
  logic [RF_ADDR_WIDTH-1:0]  rd_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
  logic                      err_q;

  always_comb begin
    ready_o    = (state_q == WB_IDLE) || (state_q == WB_COMMIT);
    rready_o   = (state_q == WB_WAIT_RSP);
    accept     = valid_i && ready_o;
    gpr_we_o   = 1'b0;
    csr_we_o   = 1'b0;
    retire_o   = 1'b0;
    load_err_o = 1'b0;
    timeout_o  = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 1'b1;
    instret_d  = instret_q;
    case (state_q)
      WB_WAIT_RSP: begin
        // A response arriving on the limit cycle still wins over the timeout.
        if (rvalid_i) begin
          cnt_d   = '0;
          state_d = WB_COMMIT;
        end else if (cnt_inc == CNT_LIMIT) begin
          timeout_o = 1'b1;
          cnt_d     = '0;
          state_d   = WB_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WB_COMMIT: begin
        gpr_we_o   = (gpr_ctrl_q != GPR_IDLE) && (rd_q != '0) && !err_q;
        csr_we_o   = (csr_ctrl_q != CSR_IDLE) && !err_q;
        retire_o   = !err_q;
        load_err_o = err_q;
        if (!err_q) instret_d = instret_q + 1'b1;
        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
    if (accept) state_d = (gpr_ctrl_i == GPR_MEM) ? WB_WAIT_RSP : WB_COMMIT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WB_IDLE;
      cnt_q       <= '0;
      instret_q   <= '0;
      gpr_ctrl_q  <= GPR_IDLE;
      csr_ctrl_q  <= CSR_IDLE;
      mem_ctrl_q  <= MEM_IDLE;
      exe_out_q   <= '0;
      op3_q       <= '0;
      rdata_q     <= '0;
      rd_q        <= '0;
      csr_waddr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      if (accept) begin
        gpr_ctrl_q  <= gpr_ctrl_i;
        csr_ctrl_q  <= csr_ctrl_i;
        mem_ctrl_q  <= mem_ctrl_i;
        exe_out_q   <= exe_out_i;
        op3_q       <= op3_i;
        rd_q        <= rd_i;
        csr_waddr_q <= csr_waddr_i;
        err_q       <= 1'b0;
      end
      if ((state_q == WB_WAIT_RSP) && rvalid_i) begin
        rdata_q <= rdata_i;
        err_q   <= err_i;
      end
    end
  end

  assign instret_o = instret_q;

  writeback_unit u_wb_unit (
    .gpr_ctrl_i  (gpr_ctrl_q),
    .mem_ctrl_i  (mem_ctrl_q),
    .exe_out_i   (exe_out_q),
    .op3_i       (op3_q),
    .rdata_i     (rdata_q),
    .rd_i        (rd_q),
    .csr_waddr_i (csr_waddr_q),
    .rd_o        (rd_o),
    .gpr_wdata_o (gpr_wdata_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o)
  );

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: stimulus pushes expected commit/pulse events with
// their cycle stamps; a negedge monitor pops and compares whenever any strobe is high.
module tb_writeback_ctrl;
  import core_pkg::*;

  localparam int TMO = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      valid_i = 1'b0;
  logic                      ready_o;
  logic [DATA_WIDTH-1:0]     exe_out_i = '0;
  logic [DATA_WIDTH-1:0]     op3_i = '0;
  logic [RF_ADDR_WIDTH-1:0]  rd_i = '0;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i = '0;
  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_i = GPR_IDLE;
  logic [CSR_CTRL_WIDTH-1:0] csr_ctrl_i = CSR_IDLE;
  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i = MEM_IDLE;
  logic                      rvalid_i = 1'b0;
  logic                      rready_o;
  logic [DATA_WIDTH-1:0]     rdata_i = '0;
  logic                      err_i = 1'b0;
  logic [RF_ADDR_WIDTH-1:0]  rd_o;
  logic [DATA_WIDTH-1:0]     gpr_wdata_o;
  logic                      gpr_we_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o;
  logic [DATA_WIDTH-1:0]     csr_wdata_o;
  logic                      csr_we_o;
  logic                      retire_o;
  logic                      load_err_o;
  logic                      timeout_o;
  logic [63:0]               instret_o;

  writeback_ctrl #(.RSP_TIMEOUT(TMO), .INSTRET_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .exe_out_i(exe_out_i), .op3_i(op3_i), .rd_i(rd_i), .csr_waddr_i(csr_waddr_i),
    .gpr_ctrl_i(gpr_ctrl_i), .csr_ctrl_i(csr_ctrl_i), .mem_ctrl_i(mem_ctrl_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .err_i(err_i),
    .rd_o(rd_o), .gpr_wdata_o(gpr_wdata_o), .gpr_we_o(gpr_we_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_we_o(csr_we_o),
    .retire_o(retire_o), .load_err_o(load_err_o), .timeout_o(timeout_o),
    .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        gpr_we;
    logic [4:0]  rd;
    logic [31:0] gdat;
    logic        csr_we;
    logic [11:0] caddr;
    logic [31:0] cdat;
    logic        retire;
    logic        lerr;
    logic        tout;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int unsigned t0;

  task automatic push(input int unsigned c, input logic gwe, input logic [4:0] rd,
                      input logic [31:0] gd, input logic cwe, input logic [11:0] ca,
                      input logic [31:0] cd, input logic ret, input logic le, input logic to);
    exp_t e;
    e.cyc = c; e.gpr_we = gwe; e.rd = rd; e.gdat = gd; e.csr_we = cwe; e.caddr = ca;
    e.cdat = cd; e.retire = ret; e.lerr = le; e.tout = to;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] g, input logic [1:0] c, input logic [3:0] m,
                       input logic [31:0] exe, input logic [31:0] o3, input logic [4:0] rd,
                       input logic [11:0] ca);
    valid_i = 1'b1; gpr_ctrl_i = g; csr_ctrl_i = c; mem_ctrl_i = m;
    exe_out_i = exe; op3_i = o3; rd_i = rd; csr_waddr_i = ca;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; gpr_ctrl_i = GPR_IDLE; csr_ctrl_i = CSR_IDLE; mem_ctrl_i = MEM_IDLE;
  endtask

  // Monitor: every strobe/pulse cycle must match the next expected event.
  exp_t e_m;
  logic ok_m;
  always @(negedge clk_i) begin
    if (gpr_we_o || csr_we_o || retire_o || load_err_o || timeout_o) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d gpr_we=%b rd=%0d csr_we=%b retire=%b load_err=%b timeout=%b, required none",
                 cyc, gpr_we_o, rd_o, csr_we_o, retire_o, load_err_o, timeout_o);
      end else begin
        e_m = sb.pop_front();
        ok_m = (cyc == e_m.cyc) && (gpr_we_o == e_m.gpr_we) && (csr_we_o == e_m.csr_we) &&
               (retire_o == e_m.retire) && (load_err_o == e_m.lerr) && (timeout_o == e_m.tout);
        if (e_m.gpr_we) ok_m = ok_m && (rd_o == e_m.rd) && (gpr_wdata_o == e_m.gdat);
        if (e_m.csr_we) ok_m = ok_m && (csr_waddr_o == e_m.caddr) && (csr_wdata_o == e_m.cdat);
        if (!ok_m) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d gwe=%b rd=%0d gd=%h cwe=%b ca=%h cd=%h ret=%b le=%b to=%b; required cyc=%0d gwe=%b rd=%0d gd=%h cwe=%b ca=%h cd=%h ret=%b le=%b to=%b",
                   cyc, gpr_we_o, rd_o, gpr_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
                   retire_o, load_err_o, timeout_o, e_m.cyc, e_m.gpr_we, e_m.rd, e_m.gdat,
                   e_m.csr_we, e_m.caddr, e_m.cdat, e_m.retire, e_m.lerr, e_m.tout);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_ready", ready_o, 1);
    check("rst_rready", rready_o, 0);
    check("rst_strobes", {gpr_we_o, csr_we_o, retire_o, load_err_o, timeout_o}, 0);
    check("rst_instret", instret_o, 0);
    rst_i = 1'b0;
    tick();

    // Back-to-back ALU instructions
    issue(GPR_ALU, CSR_IDLE, MEM_IDLE, 32'h1234, 32'h0, 5'd5, 12'h0);
    t0 = cyc;
    push(t0 + 1, 1, 5'd5, 32'h1234, 0, 0, 0, 1, 0, 0);
    tick();
    check("b2b_ready", ready_o, 1);
    issue(GPR_ALU, CSR_IDLE, MEM_IDLE, 32'h55, 32'h0, 5'd6, 12'h0);
    push(t0 + 2, 1, 5'd6, 32'h55, 0, 0, 0, 1, 0, 0);
    tick();
    idle_in();
    tick();
    check("b2b_instret", instret_o, 2);

    // Signed byte load at offset 1, response three cycles after accept
    issue(GPR_MEM, CSR_IDLE, MEM_RB, 32'h1001, 32'h0, 5'd7, 12'h0);
    t0 = cyc;
    tick();
    idle_in();
    check("lb_ready_wait", ready_o, 0);
    check("lb_rready", rready_o, 1);
    tick();
    check("lb_ready_wait2", ready_o, 0);
    tick();
    rvalid_i = 1'b1; rdata_i = 32'h0000_8000;
    push(t0 + 4, 1, 5'd7, 32'hFFFF_FF80, 0, 0, 0, 1, 0, 0);
    check("lb_ready_rsp", ready_o, 0);
    tick();
    rvalid_i = 1'b0;
    check("lb_ready_commit", ready_o, 1);
    tick();

    // Load with error response
    issue(GPR_MEM, CSR_IDLE, MEM_RW, 32'h2000, 32'h0, 5'd8, 12'h0);
    t0 = cyc;
    tick();
    idle_in();
    rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    push(t0 + 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    rvalid_i = 1'b0; err_i = 1'b0;
    tick();
    tick();
    check("lerr_instret", instret_o, 3);

    // Timeout, then a stray response
    issue(GPR_MEM, CSR_IDLE, MEM_RW, 32'h3000, 32'h0, 5'd9, 12'h0);
    t0 = cyc;
    push(t0 + TMO, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle_in();
    repeat (TMO - 1) tick();
    check("tmo_ready_pulse", ready_o, 0);
    tick();
    check("tmo_ready_after", ready_o, 1);
    check("tmo_rready_after", rready_o, 0);
    rvalid_i = 1'b1; rdata_i = 32'h1111_1111;
    tick();
    rvalid_i = 1'b0;
    tick();
    check("tmo_instret", instret_o, 3);

    // Response on the limit cycle wins over the timeout
    issue(GPR_MEM, CSR_IDLE, MEM_RW, 32'h3004, 32'h0, 5'd9, 12'h0);
    t0 = cyc;
    tick();
    idle_in();
    repeat (TMO - 1) tick();
    rvalid_i = 1'b1; rdata_i = 32'hCAFE_BABE;
    push(t0 + TMO + 1, 1, 5'd9, 32'hCAFE_BABE, 0, 0, 0, 1, 0, 0);
    tick();
    rvalid_i = 1'b0;
    tick();
    check("edge_instret", instret_o, 4);

    // CSR write with GPR_OP3 to x0
    issue(GPR_OP3, CSR_ALU, MEM_IDLE, 32'h0000_A5A5, 32'h1111, 5'd0, 12'h300);
    push(cyc + 1, 0, 0, 0, 1, 12'h300, 32'h0000_A5A5, 1, 0, 0);
    tick();
    idle_in();
    tick();
    check("csr_instret", instret_o, 5);

    // Load accepted during the commit cycle of an ALU op
    issue(GPR_ALU, CSR_IDLE, MEM_IDLE, 32'h77, 32'h0, 5'd10, 12'h0);
    t0 = cyc;
    push(t0 + 1, 1, 5'd10, 32'h77, 0, 0, 0, 1, 0, 0);
    tick();
    check("chain_ready", ready_o, 1);
    issue(GPR_MEM, CSR_IDLE, MEM_RHU, 32'h2002, 32'h0, 5'd11, 12'h0);
    tick();
    idle_in();
    rvalid_i = 1'b1; rdata_i = 32'hBEEF_0000;
    push(t0 + 3, 1, 5'd11, 32'h0000_BEEF, 0, 0, 0, 1, 0, 0);
    tick();
    rvalid_i = 1'b0;
    tick();
    check("chain_instret", instret_o, 7);

    // Reset while waiting on a load; the late response must be ignored
    issue(GPR_MEM, CSR_IDLE, MEM_RW, 32'h4000, 32'h0, 5'd12, 12'h0);
    tick();
    idle_in();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_rready", rready_o, 0);
    check("mid_rst_instret", instret_o, 0);
    rvalid_i = 1'b1; rdata_i = 32'h5555_5555;
    repeat (2) tick();
    rvalid_i = 1'b0;
    repeat (2) tick();
    check("mid_rst_strobes", {gpr_we_o, csr_we_o, retire_o, load_err_o, timeout_o}, 0);
    check("post_rst_instret", instret_o, 0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
